// File: rtl/edge_stream_packer.sv
// rtl/edge_stream_packer.sv - Sobel magnitude thresholder with framed stream output FIFO; THRESH_BINARY_EN selects binary output
module edge_stream_packer #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [8*PIXELS_PER_BEAT-1:0] in_data,
  input  logic                         in_valid,
  output logic                         stall,
  input  logic [7:0]                   thresh,
  output logic [8*PIXELS_PER_BEAT-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic                         frame_done
);

  localparam int DATA_WIDTH    = 8 * PIXELS_PER_BEAT;
  localparam int BEATS_PER_ROW = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int COL_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int ROW_W         = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = PTR_W + 1;
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMAGE_DIM - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s1_valid;
  logic [7:0]            r_thr_lat;
  logic [COL_W-1:0]      r_in_col;
  logic [ROW_W-1:0]      r_in_row;
  logic [COL_W-1:0]      r_out_col;
  logic [ROW_W-1:0]      r_out_row;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_frame_done;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_in_first;
  logic                  w_out_col_last;
  logic                  w_out_row_last;
  logic [CNT_W:0]        w_occupancy;
  logic [DATA_WIDTH-1:0] w_s1_out;

  // Occupancy counts the beat sitting in S1 so every accepted beat has a FIFO slot reserved.
  assign w_occupancy    = (CNT_W + 1)'(r_count) + (CNT_W + 1)'(r_s1_valid);
  assign stall          = (w_occupancy >= DEPTH_OCC);
  assign w_accept       = in_valid & ~stall;
  assign w_in_first     = (r_in_col == '0) && (r_in_row == '0);
  assign w_push         = r_s1_valid;
  assign m_axis_tvalid  = (r_count != '0);
  assign w_pop          = m_axis_tvalid & m_axis_tready;
  assign w_out_col_last = (r_out_col == LAST_COL);
  assign w_out_row_last = (r_out_row == LAST_ROW);
  assign m_axis_tdata   = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;
  assign m_axis_tlast   = m_axis_tvalid & w_out_col_last;
  assign m_axis_tuser   = m_axis_tvalid & (r_out_col == '0) & (r_out_row == '0);
  assign frame_done     = r_frame_done;

  // Per-pixel threshold applied to the S1 beat as it is written into the FIFO.
  always_comb begin
    w_s1_out = '0;
    for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
      if (r_s1_data[8*j +: 8] >= r_thr_lat) begin
`ifdef THRESH_BINARY_EN
        w_s1_out[8*j +: 8] = 8'hFF;
`else
        w_s1_out[8*j +: 8] = r_s1_data[8*j +: 8];
`endif
      end
    end
  end

  // S1 register captures accepted beats; the threshold is sampled at frame beat 0 only.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_thr_lat  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= in_data;
        if (w_in_first) begin
          r_thr_lat <= thresh;
        end
      end
    end
  end

  // Input-side frame position, advanced on every accepted beat.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_in_col <= '0;
      r_in_row <= '0;
    end else if (w_accept) begin
      if (r_in_col == LAST_COL) begin
        r_in_col <= '0;
        r_in_row <= (r_in_row == LAST_ROW) ? '0 : r_in_row + ROW_W'(1);
      end else begin
        r_in_col <= r_in_col + COL_W'(1);
      end
    end
  end

  // Output FIFO storage; entries need no reset because tdata is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_s1_out;
    end
  end

  // FIFO pointers and fill count; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Output-side frame position and end-of-frame pulse, advanced on each handshake.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop & w_out_col_last & w_out_row_last;
      if (w_pop) begin
        if (w_out_col_last) begin
          r_out_col <= '0;
          r_out_row <= w_out_row_last ? '0 : r_out_row + ROW_W'(1);
        end else begin
          r_out_col <= r_out_col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_stream_packer.sv
// tb/tb_edge_stream_packer.sv - directed self-checking bench for edge_stream_packer
module tb_edge_stream_packer;

  localparam int PPB    = 16;
  localparam int DIM    = 512;
  localparam int DW     = 8 * PPB;
  localparam int BPR    = DIM / PPB;
  localparam int NBEATS = BPR * DIM;
  localparam int LIMIT  = 40000;

`ifdef THRESH_BINARY_EN
  localparam logic [7:0] P40 = 8'hFF;
  localparam logic [7:0] P41 = 8'hFF;
  localparam logic [7:0] P80 = 8'hFF;
  localparam logic [7:0] PC8 = 8'hFF;
  localparam logic [7:0] PF0 = 8'hFF;
`else
  localparam logic [7:0] P40 = 8'h40;
  localparam logic [7:0] P41 = 8'h41;
  localparam logic [7:0] P80 = 8'h80;
  localparam logic [7:0] PC8 = 8'hC8;
  localparam logic [7:0] PF0 = 8'hF0;
`endif

  logic          clk;
  logic          aresetn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          stall;
  logic [7:0]    thresh;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          frame_done;

  int n_cmp;
  int n_err;

  edge_stream_packer #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM(DIM),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .in_data(in_data),
    .in_valid(in_valid),
    .stall(stall),
    .thresh(thresh),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [7:0] p);
    return {PPB{p}};
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] v, input int j, input logic [7:0] p);
    logic [DW-1:0] r;
    r = v;
    r[DW-8*(j+1) +: 8] = p;
    return r;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    aresetn  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    aresetn  = 1'b1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (stall && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: stall=%b after %0d cycles, required 0", stall, guard);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    aresetn       = 1'b0;
    in_valid      = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b required 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser: got %b required 0", m_axis_tuser); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    n_cmp++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h required 0", m_axis_tdata); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b required 0", stall); end
    aresetn = 1'b1;
  endtask

  task automatic test_basic;
    do_reset();
    thresh        = 8'd64;
    m_axis_tready = 1'b1;
    send_beat(fill(8'h40));
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_latency1: tvalid got %b required 0", m_axis_tvalid); end
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL basic_tvalid: got %b required 1", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== fill(P40)) begin n_err++; $display("FAIL basic_tdata: got %h required %h", m_axis_tdata, fill(P40)); end
    n_cmp++; if (m_axis_tuser !== 1'b1) begin n_err++; $display("FAIL basic_tuser: got %b required 1", m_axis_tuser); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL basic_tlast: got %b required 0", m_axis_tlast); end
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_drained: tvalid got %b required 0", m_axis_tvalid); end
  endtask

  task automatic test_threshold_bytes;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    do_reset();
    thresh        = 8'd64;
    m_axis_tready = 1'b1;
    d = put(put(put(fill(8'h00), 0, 8'h3F), 1, 8'h40), 2, 8'h41);
    e = put(put(fill(8'h00), 1, P40), 2, P41);
    send_beat(d);
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL bytes_tvalid: got %b required 1", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== e) begin n_err++; $display("FAIL bytes_tdata: got %h required %h", m_axis_tdata, e); end
  endtask

  task automatic test_backpressure;
    int acc;
    int rx;
    int bad_hold;
    logic took;
    logic [DW-1:0] e;
    do_reset();
    thresh        = 8'h60;
    m_axis_tready = 1'b0;
    acc           = 0;
    bad_hold      = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = put(fill(8'h10), acc % PPB, 8'hF0);
      if (m_axis_tvalid && m_axis_tdata !== put(fill(8'h00), 0, PF0)) bad_hold++;
      took = !stall;
      @(posedge clk);
      if (took) acc++;
    end
    @(negedge clk);
    n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d required 4", acc); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL bp_stall_high: got %b required 1", stall); end
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid: got %b required 1", m_axis_tvalid); end
    n_cmp++; if (bad_hold !== 0) begin n_err++; $display("FAIL bp_hold_stable: %0d unstable cycles, required 0", bad_hold); end
    in_valid      = 1'b0;
    m_axis_tready = 1'b1;
    rx            = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_axis_tvalid) begin
        e = put(fill(8'h00), rx, PF0);
        n_cmp++; if (m_axis_tdata !== e) begin n_err++; $display("FAIL bp_order_%0d: got %h required %h", rx, m_axis_tdata, e); end
        rx++;
      end
      @(negedge clk);
    end
    n_cmp++; if (rx !== 4) begin n_err++; $display("FAIL bp_emitted: got %0d required 4", rx); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL bp_stall_low: got %b required 0", stall); end
  endtask

  task automatic test_full_frame;
    int sent;
    int rx;
    int d_cyc;
    int m_cyc;
    int fd_cnt;
    int last_cnt;
    int user_cnt;
    int bad_data;
    int bad_last;
    int bad_user;
    logic took;
    do_reset();
    sent = 0; rx = 0; d_cyc = 0; m_cyc = 0; fd_cnt = 0;
    last_cnt = 0; user_cnt = 0; bad_data = 0; bad_last = 0; bad_user = 0;
    thresh = 8'd64;
    fork
      begin
        while (sent < NBEATS && d_cyc < LIMIT) begin
          @(negedge clk);
          d_cyc++;
          thresh   = (sent >= 100) ? 8'd200 : 8'd64;
          in_valid = 1'b1;
          in_data  = fill(8'h80);
          took     = !stall;
          @(posedge clk);
          if (took) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        while (rx < NBEATS && m_cyc < LIMIT) begin
          @(negedge clk);
          m_cyc++;
          m_axis_tready = ($urandom_range(0, 3) != 0);
          fd_cnt += int'(frame_done);
          if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tdata !== fill(P80)) bad_data++;
            if (m_axis_tlast !== ((rx % BPR) == BPR - 1)) bad_last++;
            if (m_axis_tuser !== (rx == 0)) bad_user++;
            last_cnt += int'(m_axis_tlast);
            user_cnt += int'(m_axis_tuser);
            rx++;
          end
        end
      end
    join
    n_cmp++; if (fd_cnt !== 0) begin n_err++; $display("FAIL frame_done_early: got %0d pulses required 0", fd_cnt); end
    @(negedge clk);
    m_axis_tready = 1'b1;
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL frame_done_pulse: got %b required 1", frame_done); end
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL frame_done_width: got %b required 0", frame_done); end
    n_cmp++; if (rx !== NBEATS) begin n_err++; $display("FAIL frame_beats: got %0d required %0d", rx, NBEATS); end
    n_cmp++; if (last_cnt !== DIM) begin n_err++; $display("FAIL frame_tlast_count: got %0d required %0d", last_cnt, DIM); end
    n_cmp++; if (user_cnt !== 1) begin n_err++; $display("FAIL frame_tuser_count: got %0d required 1", user_cnt); end
    n_cmp++; if (bad_last !== 0) begin n_err++; $display("FAIL frame_tlast_position: %0d misplaced, required 0", bad_last); end
    n_cmp++; if (bad_user !== 0) begin n_err++; $display("FAIL frame_tuser_position: %0d misplaced, required 0", bad_user); end
    n_cmp++; if (bad_data !== 0) begin n_err++; $display("FAIL frame_midframe_thresh: %0d beats altered, required 0", bad_data); end
  endtask

  task automatic test_thresh_next_frame;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    thresh        = 8'd200;
    m_axis_tready = 1'b1;
    d = put(put(put(put(fill(8'h00), 0, 8'h80), 1, 8'hC7), 2, 8'hC8), 3, 8'hFF);
    e = put(put(fill(8'h00), 2, PC8), 3, 8'hFF);
    send_beat(d);
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL next_frame_tvalid: got %b required 1", m_axis_tvalid); end
    n_cmp++; if (m_axis_tuser !== 1'b1) begin n_err++; $display("FAIL next_frame_tuser: got %b required 1", m_axis_tuser); end
    n_cmp++; if (m_axis_tdata !== e) begin n_err++; $display("FAIL next_frame_thresh200: got %h required %h", m_axis_tdata, e); end
  endtask

  task automatic test_reset_midframe;
    do_reset();
    thresh        = 8'd64;
    m_axis_tready = 1'b0;
    repeat (3) send_beat(fill(8'h80));
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL midrst_buffered: tvalid got %b required 1", m_axis_tvalid); end
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid: got %b required 0", m_axis_tvalid); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b required 0", stall); end
    thresh        = 8'h90;
    m_axis_tready = 1'b1;
    send_beat(fill(8'h80));
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL midrst_new_tvalid: got %b required 1", m_axis_tvalid); end
    n_cmp++; if (m_axis_tuser !== 1'b1) begin n_err++; $display("FAIL midrst_new_tuser: got %b required 1", m_axis_tuser); end
    n_cmp++; if (m_axis_tdata !== fill(8'h00)) begin n_err++; $display("FAIL midrst_new_thresh: got %h required %h", m_axis_tdata, fill(8'h00)); end
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_no_stale: tvalid got %b required 0", m_axis_tvalid); end
  endtask

  initial begin
    clk           = 1'b0;
    aresetn       = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    thresh        = 8'd0;
    m_axis_tready = 1'b0;
    n_cmp         = 0;
    n_err         = 0;
    test_reset();
    test_basic();
    test_threshold_bytes();
    test_backpressure();
    test_full_frame();
    test_thresh_next_frame();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
